// File: rtl/byte_mem_pkg.sv
// rtl/byte_mem_pkg.sv - shared size encodings, FSM state type and lane helpers for byte_mem
package byte_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Access byte count, clamped to the bus width in bytes.
    function automatic int size_bytes(input logic [1:0] size, input int nb);
        int n;
        n = 1 << size;
        return (n > nb) ? nb : n;
    endfunction

    function automatic int byte_of_lane(input int lane, input int off, input int nb);
        return (lane + nb - off) % nb;
    endfunction

    function automatic int lane_of_byte(input int k, input int off, input int nb);
        return (k + off) % nb;
    endfunction

endpackage

// File: rtl/byte_mem_if.sv
// rtl/byte_mem_if.sv - request/response handshake bundle between requester and byte_mem
interface byte_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              clear_busy;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, clear_busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, clear_busy
    );

endinterface

// File: rtl/byte_mem_mem_bank.sv
// rtl/byte_mem_mem_bank.sv - one 8-bit byte lane: single port, sync write, registered read
module mem_bank #(
    parameter int ROWS  = 512,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [ROW_W-1:0] i_addr,
    input  logic [7:0]       i_wdata,
    output logic [7:0]       o_rdata
);

    logic [7:0] r_mem [ROWS];
    logic [7:0] r_rdata;

    // Read data only updates on a read, so it stays put while a response is stalled.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/byte_mem.sv
// rtl/byte_mem.sv - byte-addressed little-endian data memory with per-lane banks and zero-fill
module byte_mem
    import byte_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 1024
) (
    input  logic     clk,
    input  logic     rst,
    byte_mem_if.slave bus
);

    localparam int NB     = DATA_W / 8;
    localparam int ROWS   = DEPTH_BYTES / NB;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ROW_W-1:0]    r_clr_cnt;
    logic                r_rsp_valid;
    logic [LANE_W-1:0]   r_off;
    logic [1:0]          r_size;

    logic                w_clear;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic [LANE_W-1:0]   w_off;
    logic [ROW_W-1:0]    w_row;
    logic [ROW_W-1:0]    w_row_inc;
    logic [DATA_W-1:0]   w_rdata;

    logic                w_bank_en    [NB];
    logic                w_bank_we    [NB];
    logic [ROW_W-1:0]    w_bank_addr  [NB];
    logic [7:0]          w_bank_wdata [NB];
    logic [7:0]          w_bank_rdata [NB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_req_ready = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clear = 1'b1;
                if (r_clr_cnt == ROW_W'(ROWS - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_req_ready = !(r_rsp_valid && !bus.rsp_ready);
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (w_clear) begin
            r_clr_cnt <= r_clr_cnt + ROW_W'(1);
        end
    end

    assign w_accept  = bus.req_valid && w_req_ready;
    assign w_rd_acc  = w_accept && !bus.req_we;
    assign w_wr_acc  = w_accept && bus.req_we;

    // Only the low log2(DEPTH_BYTES) address bits matter; truncation gives the row wrap.
    assign w_off     = LANE_W'(bus.req_addr % ADDR_W'(NB));
    assign w_row     = ROW_W'(bus.req_addr / ADDR_W'(NB));
    assign w_row_inc = w_row + ROW_W'(1);

    always_comb begin
        for (int j = 0; j < NB; j++) begin
            w_bank_en[j]    = 1'b0;
            w_bank_we[j]    = 1'b0;
            w_bank_addr[j]  = w_row;
            w_bank_wdata[j] = 8'h00;
            if (w_clear) begin
                w_bank_en[j]   = 1'b1;
                w_bank_we[j]   = 1'b1;
                w_bank_addr[j] = r_clr_cnt;
            end else begin
                // Lanes below the start offset hold the spill-over bytes of the next row.
                w_bank_addr[j]  = (j >= int'(w_off)) ? w_row : w_row_inc;
                w_bank_wdata[j] = bus.req_wdata[8*byte_of_lane(j, int'(w_off), NB) +: 8];
                if (w_rd_acc) begin
                    w_bank_en[j] = 1'b1;
                end
                if (w_wr_acc &&
                    byte_of_lane(j, int'(w_off), NB) < size_bytes(bus.req_size, NB)) begin
                    w_bank_en[j] = 1'b1;
                    w_bank_we[j] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_bank
        mem_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk     (clk),
            .i_en    (w_bank_en[g]),
            .i_we    (w_bank_we[g]),
            .i_addr  (w_bank_addr[g]),
            .i_wdata (w_bank_wdata[g]),
            .o_rdata (w_bank_rdata[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_off       <= '0;
            r_size      <= SZ_B;
        end else if (w_rd_acc) begin
            r_rsp_valid <= 1'b1;
            r_off       <= w_off;
            r_size      <= bus.req_size;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Realign lanes back to byte order; gating on valid keeps the unreset bank outputs hidden.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NB; k++) begin
            if (r_rsp_valid && (k < size_bytes(r_size, NB))) begin
                w_rdata[8*k +: 8] = w_bank_rdata[lane_of_byte(k, int'(r_off), NB)];
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = w_rdata;
    assign bus.clear_busy = (r_state == CLEAR);

endmodule

// File: tb/tb_byte_mem.sv
// tb/tb_byte_mem.sv - randomized self-checking bench for byte_mem against a byte-array model
module tb_byte_mem;
    import byte_mem_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 1024;
    localparam int NB     = DATA_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    byte_mem #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH_BYTES (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] last_rsp = '0;
    int          n_rsp = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    logic drv_rdy = 1'b1;
    logic rnd_rdy = 1'b1;
    logic use_rnd = 1'b0;
    assign bus.rsp_ready = use_rnd ? rnd_rdy : drv_rdy;

    always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        int n;
        n = 1 << size;
        if (n > NB) n = NB;
        return n;
    endfunction

    function automatic logic [15:0] model_read(input int addr, input logic [1:0] size);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < nbytes(size); k++) v[8*k +: 8] = model[(addr + k) % DEPTH];
        return v;
    endfunction

    // Observe at the falling edge: whatever handshakes are true now complete at the next rise.
    always @(negedge clk) begin
        if (rst) begin
            foreach (model[i]) model[i] = 8'h00;
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                if (prev_stall) check("rsp_hold", bus.rsp_rdata, prev_data);
                if (bus.rsp_ready) begin
                    check("rsp_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
                        last_rsp = bus.rsp_rdata;
                        n_rsp++;
                    end
                end else begin
                    check("stall_req_ready", bus.req_ready, 0);
                end
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev_data  = bus.rsp_rdata;
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) begin
                    for (int k = 0; k < nbytes(bus.req_size); k++)
                        model[(int'(bus.req_addr) + k) % DEPTH] = bus.req_wdata[8*k +: 8];
                end else begin
                    exp_q.push_back(model_read(int'(bus.req_addr), bus.req_size));
                end
            end
        end
    end

    task automatic issue(input logic we, input int addr, input logic [1:0] size, input logic [15:0] wd);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_size  = size;
        bus.req_wdata = wd;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.req_ready;
            t++;
            @(posedge clk);
            #1;
        end
        if (!acc) check("req_accept_timeout", acc, 1);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("drain_timeout", t < 200, 1);
    endtask

    task automatic wr(input int addr, input logic [1:0] size, input logic [15:0] wd);
        issue(1'b1, addr, size, wd);
        idle();
    endtask

    task automatic rd(input string tag, input int addr, input logic [1:0] size, input logic [15:0] exp);
        issue(1'b0, addr, size, 16'h0000);
        idle();
        drain();
        check(tag, last_rsp, exp);
    endtask

    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        while (bus.clear_busy && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check(tag, cnt, 512);
        check({tag, "_ready"}, bus.req_ready, 1);
    endtask

    initial begin
        int n0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = SZ_B;
        bus.req_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_clear_busy", bus.clear_busy, 1);
        @(negedge clk);
        rst = 1'b0;
        wait_clear("clear_cycles");
        @(posedge clk);
        #1;

        rd("rd_init", 16'h0000, SZ_H, 16'h0000);
        wr(16'h0010, SZ_H, 16'hBEEF);
        rd("rd_aligned_h", 16'h0010, SZ_H, 16'hBEEF);
        rd("rd_aligned_b", 16'h0011, SZ_B, 16'h00BE);
        wr(16'h0021, SZ_H, 16'h1234);
        rd("rd_mis_lo", 16'h0020, SZ_H, 16'h3400);
        rd("rd_mis_hi", 16'h0022, SZ_H, 16'h0012);
        wr(16'h03FF, SZ_H, 16'hA55A);
        rd("rd_wrap_top", 16'h03FF, SZ_B, 16'h005A);
        rd("rd_wrap_zero", 16'h0000, SZ_B, 16'h00A5);
        rd("rd_alias_400", 16'h0400, SZ_B, 16'h00A5);
        rd("rd_wrap_h", 16'h03FF, SZ_H, 16'hA55A);
        rd("rd_size_clamp", 16'h0010, SZ_D, 16'hBEEF);
        rd("rd_upper_ignored", 16'hFC10, SZ_W, 16'hBEEF);
        wr(16'h0011, SZ_B, 16'hFF77);
        rd("rd_byte_merge", 16'h0010, SZ_H, 16'h77EF);

        issue(1'b1, 16'h0040, SZ_H, 16'hCAFE);
        issue(1'b0, 16'h0040, SZ_H, 16'h0000);
        idle();
        drain();
        check("wr_then_rd", last_rsp, 16'hCAFE);

        n0 = n_rsp;
        issue(1'b0, 16'h0010, SZ_H, 16'h0000);
        drv_rdy = 1'b0;
        fork
            begin
                issue(1'b0, 16'h0020, SZ_H, 16'h0000);
                issue(1'b0, 16'h03FF, SZ_H, 16'h0000);
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1 drv_rdy = 1'b1;
                @(posedge clk);
                #1 drv_rdy = 1'b0;
                repeat (4) @(posedge clk);
                #1 drv_rdy = 1'b1;
            end
        join
        drain();
        check("bp_rsp_count", n_rsp - n0, 3);
        check("bp_last", last_rsp, 16'hA55A);

        use_rnd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)),
                  2'($urandom_range(0, 3)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        use_rnd = 1'b0;
        drain();

        wr(16'h0100, SZ_H, 16'h5A5A);
        drv_rdy = 1'b0;
        issue(1'b0, 16'h0100, SZ_H, 16'h0000);
        idle();
        check("stall_valid", bus.rsp_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_req_ready", bus.req_ready, 0);
        check("midrst_clear_busy", bus.clear_busy, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drv_rdy = 1'b1;
        wait_clear("reclear_cycles");
        @(posedge clk);
        #1;
        rd("post_rst_100", 16'h0100, SZ_H, 16'h0000);
        rd("post_rst_010", 16'h0010, SZ_H, 16'h0000);
        rd("post_rst_3ff", 16'h03FF, SZ_H, 16'h0000);
        rd("post_rst_040", 16'h0040, SZ_H, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
